// File: rtl/console_input_mux.sv
// console_input_mux: per-channel byte FIFOs merged round-robin into one tagged stream with optional VT100 escape lock
module console_input_mux #(
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH = 16,
  parameter int ESC_LOCK = 1,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_CHANNELS-1:0] in_valid,
  input  logic [8*NUM_CHANNELS-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [7:0] out_data,
  output logic [CW-1:0] out_channel,
  output logic [NUM_CHANNELS-1:0] overflow,
  input  logic [NUM_CHANNELS-1:0] overflow_clear,
  output logic locked
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(LOCK_TIMEOUT - 1);
  typedef enum logic [1:0] {UNLOCKED, LOCK_FIRST, LOCKED} lock_t;
  lock_t state, state_n;
  logic [7:0] mem [NUM_CHANNELS][DEPTH];
  logic [AW-1:0] wr_ptr [NUM_CHANNELS];
  logic [AW-1:0] rd_ptr [NUM_CHANNELS];
  logic [AW:0] cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ready_ch, pop, push;
  logic [CW-1:0] last, gnt, idx, lock_ch;
  logic [TW-1:0] timer;
  logic [7:0] gnt_byte;
  logic lk, any, go, tmo;
  assign lk = ESC_LOCK != 0 && state != UNLOCKED;
  assign locked = lk;
  assign go = (!out_valid || out_ready) && any;
  assign gnt_byte = mem[gnt][rd_ptr[gnt]];
  assign tmo = lk && cnt[lock_ch] == '0 && timer == TMAX;
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ready_ch[i] = cnt[i] != '0 && (!lk || lock_ch == CW'(i));
      pop[i] = go && gnt == CW'(i);
      push[i] = in_valid[i] && (cnt[i] != FULL || pop[i]);
    end
  end
  always_comb begin
    gnt = last;
    any = 1'b0;
    idx = last;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = idx == CW'(NUM_CHANNELS - 1) ? '0 : idx + 1'b1;
      if (!any && ready_ch[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    if (go) begin
      if (gnt_byte == 8'h1B) state_n = LOCK_FIRST;
      else if (state == LOCK_FIRST) state_n = (gnt_byte == 8'h5B || gnt_byte == 8'h5D) ? LOCKED : UNLOCKED;
      else if (state == LOCKED && ((gnt_byte >= 8'h40 && gnt_byte <= 8'h7E) || gnt_byte == 8'h07 || gnt_byte == 8'h18))
        state_n = UNLOCKED;
    end else if (tmo) state_n = UNLOCKED;
    if (ESC_LOCK == 0) state_n = UNLOCKED;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED;
      lock_ch <= '0;
      timer <= '0;
      last <= CW'(NUM_CHANNELS - 1);
      out_valid <= 1'b0;
      out_data <= '0;
      out_channel <= '0;
      overflow <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      state <= state_n;
      timer <= (go || state_n == UNLOCKED) ? '0 : (lk && cnt[lock_ch] == '0) ? timer + 1'b1 : timer;
      if (go && gnt_byte == 8'h1B) lock_ch <= gnt;
      if (!out_valid || out_ready) out_valid <= any;
      if (go) begin
        out_data <= gnt_byte;
        out_channel <= gnt;
        last <= gnt;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
        overflow[i] <= (in_valid[i] && !push[i]) || (overflow[i] && !overflow_clear[i]);
      end
    end
  end
endmodule

// File: tb/tb_console_input_mux.sv
// tb_console_input_mux: directed scenario tasks for the 4-channel mux with an 8-cycle lock timeout
module tb_console_input_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [31:0] in_data = '0;
  logic out_valid, locked;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_channel;
  logic [3:0] overflow;
  logic [3:0] overflow_clear = '0;
  int vectors = 0;
  int errors = 0;
  localparam logic [10:0] ESC_EXP [7] = '{
    {2'd1, 8'h1B, 1'b1}, {2'd1, 8'h5B, 1'b1}, {2'd1, 8'h33, 1'b1}, {2'd1, 8'h31, 1'b1},
    {2'd1, 8'h6D, 1'b0}, {2'd0, 8'h41, 1'b0}, {2'd0, 8'h42, 1'b0}};

  always #5 clk = ~clk;

  console_input_mux #(.NUM_CHANNELS(4), .DEPTH(16), .ESC_LOCK(1), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_channel(out_channel), .overflow(overflow),
    .overflow_clear(overflow_clear), .locked(locked));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    in_valid = 4'b0001 << ch;
    in_data[8*ch +: 8] = b;
    tick();
    in_valid = '0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid = '0;
    overflow_clear = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    vectors++; if (out_channel !== 2'd0) begin errors++; $display("FAIL reset_out_channel got %0d want 0", out_channel); end
    vectors++; if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_overflow got %b want 0000", overflow); end
    vectors++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
  endtask

  task automatic test_latency;
    out_ready = 1'b1;
    push(2, 8'h41);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_t1 out_valid got %b want 0", out_valid); end
    tick();
    vectors++;
    if ({out_valid, out_channel, out_data} !== {1'b1, 2'd2, 8'h41}) begin
      errors++; $display("FAIL latency_t2 got v=%b ch=%0d d=%h want v=1 ch=2 d=41", out_valid, out_channel, out_data);
    end
    tick();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_t3 out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_overflow;
    int n;
    logic [9:0] exp;
    out_ready = 1'b0;
    push(3, 8'hEE);
    tick();
    for (int k = 0; k < 17; k++) begin
      push(0, 8'(k));
      if (k == 15) begin
        vectors++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b want 0", overflow[0]); end
      end
    end
    vectors++; if (overflow !== 4'b0001) begin errors++; $display("FAIL ovf_set got %b want 0001", overflow); end
    vectors++;
    if ({out_valid, out_channel, out_data} !== {1'b1, 2'd3, 8'hEE}) begin
      errors++; $display("FAIL ovf_hold got v=%b ch=%0d d=%h want v=1 ch=3 d=ee", out_valid, out_channel, out_data);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        exp = (n == 0) ? {2'd3, 8'hEE} : {2'd0, 8'(n - 1)};
        vectors++;
        if (n >= 17 || {out_channel, out_data} !== exp) begin
          errors++; $display("FAIL ovf_drain[%0d] got ch=%0d d=%h want ch=%0d d=%h", n, out_channel, out_data, exp[9:8], exp[7:0]);
        end
        n++;
      end
      tick();
    end
    vectors++; if (n !== 17) begin errors++; $display("FAIL ovf_drain_count got %0d want 17", n); end
    overflow_clear = 4'b0001;
    tick();
    overflow_clear = '0;
    vectors++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clear got %b want 0000", overflow); end
  endtask

  task automatic test_round_robin;
    int n;
    logic [9:0] exp;
    apply_reset();
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (c < 3) ? 4'hF : 4'h0;
      in_data = {8'h30, 8'h20, 8'h10, 8'h00} | {4{8'(c)}};
      if (out_valid) begin
        exp = {2'(n % 4), 8'(16 * (n % 4) + n / 4)};
        vectors++;
        if (n >= 12 || {out_channel, out_data} !== exp) begin
          errors++; $display("FAIL rr[%0d] got ch=%0d d=%h want ch=%0d d=%h", n, out_channel, out_data, exp[9:8], exp[7:0]);
        end
        n++;
      end
      tick();
    end
    in_valid = '0;
    vectors++; if (n !== 12) begin errors++; $display("FAIL rr_count got %0d want 12", n); end
  endtask

  task automatic test_esc_lock;
    int n;
    apply_reset();
    push(1, 8'h1B); push(1, 8'h5B); push(1, 8'h33); push(1, 8'h31); push(1, 8'h6D);
    push(0, 8'h41); push(0, 8'h42);
    vectors++; if (locked !== 1'b1) begin errors++; $display("FAIL esc_locked_held got %b want 1", locked); end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        vectors++;
        if (n >= 7 || {out_channel, out_data, locked} !== ESC_EXP[n < 7 ? n : 0]) begin
          errors++; $display("FAIL esc_seq[%0d] got ch=%0d d=%h lk=%b", n, out_channel, out_data, locked);
        end
        n++;
      end
      tick();
    end
    vectors++; if (n !== 7) begin errors++; $display("FAIL esc_count got %0d want 7", n); end
  endtask

  task automatic test_timeout;
    logic found;
    apply_reset();
    out_ready = 1'b1;
    push(1, 8'h1B);
    push(1, 8'h5B);
    push(0, 8'h41);
    found = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (out_valid && out_data == 8'h5B) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    vectors++; if (found !== 1'b1) begin errors++; $display("FAIL tmo_5b_seen got %b want 1", found); end
    for (int n = 1; n <= 9; n++) begin
      tick();
      vectors++;
      if (n <= 7 && {out_valid, locked} !== 2'b01) begin
        errors++; $display("FAIL tmo_hold[%0d] got v=%b lk=%b want v=0 lk=1", n, out_valid, locked);
      end else if (n == 8 && {out_valid, locked} !== 2'b00) begin
        errors++; $display("FAIL tmo_drop got v=%b lk=%b want v=0 lk=0", out_valid, locked);
      end else if (n == 9 && {out_valid, out_channel, out_data} !== {1'b1, 2'd0, 8'h41}) begin
        errors++; $display("FAIL tmo_release got v=%b ch=%0d d=%h want v=1 ch=0 d=41", out_valid, out_channel, out_data);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    apply_reset();
    push(2, 8'h1B);
    push(2, 8'h5B);
    tick();
    for (int k = 0; k < 17; k++) push(0, 8'(k));
    overflow_clear = 4'b0001;
    push(0, 8'h99);
    overflow_clear = '0;
    vectors++; if (overflow !== 4'b0001) begin errors++; $display("FAIL set_beats_clear got %b want 0001", overflow); end
    vectors++;
    if ({out_valid, locked} !== 2'b11) begin
      errors++; $display("FAIL pre_rst got v=%b lk=%b want v=1 lk=1", out_valid, locked);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out_valid, overflow, locked} !== 6'b0) begin
      errors++; $display("FAIL mid_rst got v=%b ovf=%b lk=%b want all 0", out_valid, overflow, locked);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) n++;
      tick();
    end
    vectors++; if (n !== 0) begin errors++; $display("FAIL stale_after_rst got %0d bytes want 0", n); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_round_robin();
    test_esc_lock();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/console_input_mux.md
Name: console_input_mux

Overview:
Parametrised successor to the single-UART input path of the video controller. It accepts byte strobes from NUM_CHANNELS independent receivers and buffers each channel in its own FIFO. A round-robin arbiter then merges them into one valid/ready byte stream, tagged with the source channel, for the VT100 parser. An optional escape-sequence lock keeps a VT100 control sequence from one channel contiguous on the output.

Parameters:
NUM_CHANNELS, 4, number of byte sources (1..16)
DEPTH, 16, entries per channel FIFO; power of two, >= 2
ESC_LOCK, 1, 1 = enable escape-sequence lock; 0 = pure round-robin
LOCK_TIMEOUT, 1024, cycles the locked channel may stay empty before the lock is forcibly released (>= 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_valid  input  NUM_CHANNELS  per-channel single-cycle byte strobe
in_data  input  8*NUM_CHANNELS  channel i byte is bits [8i+7:8i]
out_valid  output  1  output byte held
out_ready  input  1  consumer accepts byte this cycle
out_data  output  8  byte to parser
out_channel  output  max(1,$clog2(NUM_CHANNELS))  source channel of out_data
overflow  output  NUM_CHANNELS  sticky per-channel drop flag
overflow_clear  input  NUM_CHANNELS  per-channel clear of overflow
locked  output  1  escape lock active

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - all FIFOs empty; out_valid=0, out_data=0, out_channel=0, overflow=0, locked=0
  - last-grant pointer = NUM_CHANNELS-1, so channel 0 has first priority
  - lock timeout counter = 0
  - reset mid-transfer discards all buffered bytes and the held output byte.
- Push:
  - in_valid[i]=1 writes in_data[i] into FIFO i at the next edge if count_i < DEPTH, or if FIFO i is popped in the same cycle (count unchanged).
  - Otherwise the byte is dropped and overflow[i] is set.
  - overflow[i] stays set until overflow_clear[i]=1. If a set and a clear coincide, the set wins.
- Output register:
  - "free" = !out_valid || out_ready.
  - When free and at least one channel is eligible and non-empty, the arbiter pops one FIFO and loads out_data/out_channel; out_valid=1 at the next edge.
  - When free and nothing is eligible, out_valid=0 at the next edge.
  - Holding rule: while out_valid && !out_ready, out_data and out_channel are stable.
- Latency: a byte pushed with in_valid in cycle t appears with out_valid in cycle t+2 when the system is idle. Sustained throughput is 1 byte/cycle.
- Arbitration:
  - The arbiter grants the first non-empty eligible channel scanning last+1, last+2, ... modulo NUM_CHANNELS, then updates last = granted.
  - Channels are eligible only when they are not masked by the lock.
- Lock (ESC_LOCK=1); states UNLOCKED, LOCK_FIRST, LOCKED:
  - UNLOCKED: granting byte 0x1B from channel c gives locked=1, lock_ch=c, state LOCK_FIRST. While locked, only lock_ch is eligible.
  - LOCK_FIRST: next granted byte from lock_ch:
    - 0x5B ('[') or 0x5D (']') -> LOCKED;
    - any other byte -> UNLOCKED (two-byte escape finished).
  - LOCKED: granting a byte in 0x40..0x7E -> UNLOCKED. Byte 0x07 or 0x18 -> UNLOCKED. Any other byte stays LOCKED.
  - 0x1B granted while already locked re-enters LOCK_FIRST.
  - Timeout: the counter increments each cycle that the lock is active and FIFO lock_ch is empty. It resets on any grant. At LOCK_TIMEOUT it forces UNLOCKED, and locked drops at the next edge.
  - ESC_LOCK=0: locked is tied to 0; all channels are always eligible.
- NUM_CHANNELS=1: arbiter degenerates; out_channel=0 always.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Test Plan:
- Idle, in_valid[2]=1 with 0x41 at cycle t, out_ready=1 -> out_valid=1, out_data=0x41, out_channel=2 at cycle t+2, for exactly one cycle.
- DEPTH=16, out_ready=0, push 17 bytes 0x00..0x10 on ch0 -> overflow[0]=1 after the 17th push. Then out_ready=1 drains exactly 0x00..0x0F in order. Pulse overflow_clear[0] -> overflow[0]=0.
- Ch0..ch3 each hold 3 bytes, out_ready=1 -> out_channel sequence 0,1,2,3,0,1,2,3,0,1,2,3.
- ESC_LOCK=1: ch1 holds 1B 5B 33 31 6D and ch0 holds 41 42 -> output 1B 5B 33 31 6D from ch1 contiguously, with locked=1 from the grant of 1B until the grant of 6D, then 41 42.
- ESC_LOCK=1, LOCK_TIMEOUT=8: ch1 sends only 1B 5B, and ch0 holds 0x41 -> 0x41 is output only after locked drops, 8 cycles after the last ch1 grant.
- Assert rst while out_valid=1 with stalled out_ready and FIFOs non-empty -> next cycle out_valid=0, overflow=0, locked=0. No stale byte appears afterwards.
